// File: rtl/whack_mole_field.sv
// Whack-a-mole playfield: pops a mole at a pseudo-random hole on each mole_clk rise,
// judges whack presses as hits or misses and keeps saturating score/miss counters.
module whack_mole_field #(
    parameter int         NUM_HOLES = 4,
    parameter int         SCORE_W   = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 game_in_progress,
    input  logic                 mole_clk,
    input  logic [NUM_HOLES-1:0] whack_buttons,
    output logic [NUM_HOLES-1:0] mole_onehot,
    output logic [SCORE_W-1:0]   score,
    output logic [SCORE_W-1:0]   misses,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);

    localparam int              HW        = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;
    localparam logic [7:0]      SEED      = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0]      HOLES8    = 8'(NUM_HOLES);
    localparam logic [HW-1:0]   LAST_HOLE = HW'(NUM_HOLES - 1);
    localparam logic [SCORE_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DOWN = 2'd1;
    localparam logic [1:0] UP   = 2'd2;
    localparam logic [1:0] HIT  = 2'd3;

    logic [1:0]           state;
    logic [7:0]           lfsr;
    logic                 mole_clk_d;
    logic                 gip_d;
    logic [HW-1:0]        last_pos;

    logic                 rise;
    logic                 fall;
    logic                 gip_rise;
    logic                 any_whack;
    logic                 overlap;
    logic                 do_hit;
    logic                 do_miss;
    logic [HW-1:0]        raw_pos;
    logic [HW-1:0]        pick;
    logic [NUM_HOLES-1:0] pop_mask;

    assign rise      = mole_clk & ~mole_clk_d;
    assign fall      = ~mole_clk & mole_clk_d;
    assign gip_rise  = game_in_progress & ~gip_d;
    assign any_whack = |whack_buttons;
    assign overlap   = |(whack_buttons & mole_onehot);

    // Never pop the same hole twice in a row: bump to the next hole, wrapping.
    assign raw_pos  = HW'(lfsr % HOLES8);
    assign pick     = (raw_pos != last_pos)   ? raw_pos :
                      (raw_pos == LAST_HOLE)  ? '0      : raw_pos + HW'(1);
    assign pop_mask = NUM_HOLES'(1) << pick;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        do_hit  = 1'b0;
        do_miss = 1'b0;
        if (game_in_progress) begin
            case (state)
                DOWN, HIT: do_miss = any_whack;
                UP: begin
                    do_hit  = overlap;
                    do_miss = any_whack & ~overlap;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= SEED;
            mole_clk_d <= 1'b0;
            gip_d      <= 1'b0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            mole_clk_d <= mole_clk;
            gip_d      <= game_in_progress;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mole_onehot <= '0;
            last_pos    <= '0;
        end else if (!game_in_progress) begin
            state       <= IDLE;
            mole_onehot <= '0;
        end else begin
            case (state)
                IDLE: state <= DOWN;
                DOWN: begin
                    if (rise) begin
                        mole_onehot <= pop_mask;
                        last_pos    <= pick;
                        state       <= UP;
                    end
                end
                UP: begin
                    // A hit in the fall cycle still counts, but the mole window is over.
                    if (fall) begin
                        mole_onehot <= '0;
                        state       <= DOWN;
                    end else if (overlap) begin
                        mole_onehot <= '0;
                        state       <= HIT;
                    end
                end
                HIT: begin
                    if (fall) state <= DOWN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A fresh game start clears both counters and wins over any same-cycle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            hit_pulse  <= do_hit & ~gip_rise;
            miss_pulse <= do_miss & ~gip_rise;
            if (gip_rise) begin
                score  <= '0;
                misses <= '0;
            end else begin
                if (do_hit && score != CNT_MAX)   score  <= score + SCORE_W'(1);
                if (do_miss && misses != CNT_MAX) misses <= misses + SCORE_W'(1);
            end
        end
    end

endmodule

// File: doc/whack_mole_field.md
Name: whack_mole_field

Overview:
- Game-side consumer of the mole-timing FSM's outputs `mole_clk` and `game_in_progress`.
- On each `mole_clk` rising edge it pops a mole at a pseudo-random hole, and drops it on the falling edge.
- It judges player whack buttons as hit or miss and keeps saturating score and miss counters.
- Sits between the mole FSM and the display/score logic; everything runs in the same `clk` domain as the FSM.

Parameters:
- NUM_HOLES, 4, number of holes/whack buttons (2..8).
- SCORE_W, 8, width of score and miss counters.
- LFSR_SEED, 8'hA5, LFSR reset value; 0 is replaced by 8'h01.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- game_in_progress  input  1  high while a game runs (from mole FSM).
- mole_clk  input  1  high = mole-up window, low = mole-down window (from mole FSM).
- whack_buttons  input  NUM_HOLES  single-cycle press pulses, one bit per hole.
- mole_onehot  output  NUM_HOLES  registered; bit i set = mole visible in hole i.
- score  output  SCORE_W  registered hit count.
- misses  output  SCORE_W  registered miss count.
- hit_pulse  output  1  registered 1-cycle strobe per counted hit.
- miss_pulse  output  1  registered 1-cycle strobe per counted miss.

Behaviour:
- Reset (rst_n low, async):
  - mole_onehot=0, score=0, misses=0, hit_pulse=0, miss_pulse=0.
  - State IDLE; LFSR=LFSR_SEED; mole_clk_d=0, gip_d=0, last_pos=0.
- Edge detect uses registered copies of the inputs:
  - rise = mole_clk & ~mole_clk_d; fall = ~mole_clk & mole_clk_d.
  - gip_rise = game_in_progress & ~gip_d.
- LFSR:
  - 8-bit Fibonacci; shifts left every clk.
  - new bit0 = l[7]^l[5]^l[4]^l[3].
  - Runs regardless of state.
- Hole pick on rise:
  - p = LFSR mod NUM_HOLES.
  - If p == last_pos, use (p+1) mod NUM_HOLES instead.
  - last_pos <= chosen p.
- States:
  - IDLE: mole_onehot=0; whacks ignored. Go to DOWN when game_in_progress=1.
  - DOWN: waiting for rise. On rise: mole_onehot <= onehot(p), go to UP. A whack with any bit set here is a miss.
  - UP: mole visible.
    - Whack overlapping mole_onehot: score+1, hit_pulse, mole_onehot <= 0, go to HIT.
    - Whack with no overlap: misses+1, miss_pulse.
    - On fall: mole_onehot <= 0, go to DOWN.
  - HIT: mole already whacked; any whack is a miss. On fall go to DOWN.
- Any state with game_in_progress=0 → IDLE at the next edge: mole_onehot cleared, counters frozen, whacks ignored.
- gip_rise (any state): score <= 0 and misses <= 0 at that edge; this overrides any count in the same cycle.
- Latency:
  - mole_clk first-high cycle N → mole_onehot valid after edge N+1, i.e. one cycle after mole_clk is sampled high.
  - Whack in cycle M → score/misses/pulse updated at edge M+1.
- Simultaneous events:
  - Hit and fall in the same cycle: the hit counts; end state DOWN.
  - Whack and rise in the same cycle: judged against the current mole_onehot (0), so it is a miss. The mole still pops.
  - Multiple buttons with at least one overlapping: one hit, no miss. Multiple buttons with none overlapping: one miss.
- Counters saturate at all-ones. A pulse still fires when the counter is saturated.
- Reset mid-game: immediate clear, as listed under Reset. Resumes only via game_in_progress high.

Test Plan:
- Reset, game_in_progress=1, mole_clk toggling 10 clk high / 5 low, no whacks → exactly one mole_onehot bit set during each high window, 1-cycle delayed. Consecutive holes always differ. score=0, misses=0.
- Whack the correct hole 3 clk after the mole appears, over 5 periods → score=5, five hit_pulses, mole_onehot=0 the cycle after each hit.
- Whack the wrong hole while UP; whack during DOWN; whack again after a hit → misses=3, score unchanged.
- Simultaneous: whack the correct hole in the same cycle mole_clk falls → score+1. Whack in the rise cycle → misses+1, mole still appears.
- SCORE_W=2, 5 hits → score saturates at 3 with 5 hit_pulses. Lower game_in_progress → mole cleared, later whacks ignored. Re-raise it → score=0, misses=0.
- Assert rst_n low mid-UP → all outputs 0 asynchronously, without waiting for a clk edge. Check the sequence of chosen holes against a bench LFSR model seeded 8'hA5.
